// File: rtl/seven_seg_pkg.sv
// Shared segment encoding for the seven-segment scan driver.
// Patterns are active-low {g,f,e,d,c,b,a}: a 0 bit lights that segment.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Entries run from F (index 15) down to 0 (index 0).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Hex nibble to active-low segment pattern, forced dark when blanked.
// Purely combinational, zero latency, no flow control.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_OFF : hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scan.sv
// N-digit multiplexed seven-segment driver with tear-free double buffering.
// Outputs registered one cycle after (idx, display regs, enable); no backpressure.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

  localparam logic [6:0]          SEG_DARK = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
  localparam logic                DP_DARK  = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_DARK  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pend_val_q, disp_val_q;
  logic [N_DIGITS-1:0]   pend_dp_q, disp_dp_q;
  logic                  pend_blz_q, disp_blz_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   an_q;
  logic                  frame_done_q;

  logic tick, wrap;
  assign tick      = (div_cnt_q == DIV_MAX) && enable;
  assign wrap      = tick && (idx_q == IDX_MAX);
  assign div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + DIV_W'(1);
  assign idx_d     = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);

  // hi_zero[i] is set when nibble i and every nibble above it are zero.
  logic [N_DIGITS-1:0] hi_zero;
  logic                run_zero;
  always_comb begin
    hi_zero  = '0;
    run_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run_zero   = run_zero && (disp_val_q[4*i +: 4] == 4'd0);
      hi_zero[i] = run_zero;
    end
  end

  logic [3:0]          nib_sel;
  logic                blank_sel, dp_sel;
  logic [6:0]          seg_dec, seg_pol;
  logic                dp_pol;
  logic [N_DIGITS-1:0] an_onehot, an_pol;

  assign nib_sel   = disp_val_q[{idx_q, 2'b00} +: 4];
  assign blank_sel = disp_blz_q && (idx_q != '0) && hi_zero[idx_q];
  assign dp_sel    = disp_dp_q[idx_q];

  seven_seg_decode u_decode (
    .nibble_i (nib_sel),
    .blank_i  (blank_sel),
    .seg_o    (seg_dec)
  );

  assign seg_pol   = (SEG_ACTIVE_LOW != 0) ? seg_dec : ~seg_dec;
  assign dp_pol    = (SEG_ACTIVE_LOW != 0) ? ~dp_sel : dp_sel;
  assign an_onehot = N_DIGITS'(1) << idx_q;
  assign an_pol    = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blz_q   <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blz_q   <= 1'b0;
      seg_q        <= SEG_DARK;
      dp_q         <= DP_DARK;
      an_q         <= AN_DARK;
      frame_done_q <= 1'b0;
    end else begin
      if (enable) div_cnt_q <= div_cnt_d;
      if (tick)   idx_q     <= idx_d;
      frame_done_q <= wrap;
      if (load) begin
        pend_val_q <= value;
        pend_dp_q  <= dp_in;
        pend_blz_q <= blank_lz;
      end
      // A load landing on the wrap tick goes straight to the new frame.
      if (wrap) begin
        disp_val_q <= load ? value    : pend_val_q;
        disp_dp_q  <= load ? dp_in    : pend_dp_q;
        disp_blz_q <= load ? blank_lz : pend_blz_q;
      end
      seg_q <= enable ? seg_pol : SEG_DARK;
      dp_q  <= enable ? dp_pol  : DP_DARK;
      an_q  <= enable ? an_pol  : AN_DARK;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (4 digits, 4 cycles per slot) with a
// frame-position model checked every cycle plus literal pin checks.
module tb_seven_seg_scan;

  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int FRAME = ND * DIV;

  logic          clk = 1'b0;
  logic          rst_n, enable, load, blank_lz;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;

  seven_seg_scan #(
    .N_DIGITS(ND), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit released = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, got, want);
    end
  endtask

  // Spec decode table, active-low {g,f,e,d,c,b,a}.
  logic [6:0] hex_seg [16];
  initial begin
    hex_seg[0]  = 7'b1000000; hex_seg[1]  = 7'b1111001; hex_seg[2]  = 7'b0100100;
    hex_seg[3]  = 7'b0110000; hex_seg[4]  = 7'b0011001; hex_seg[5]  = 7'b0010010;
    hex_seg[6]  = 7'b0000010; hex_seg[7]  = 7'b1111000; hex_seg[8]  = 7'b0000000;
    hex_seg[9]  = 7'b0010000; hex_seg[10] = 7'b0001000; hex_seg[11] = 7'b0000011;
    hex_seg[12] = 7'b1000110; hex_seg[13] = 7'b0100001; hex_seg[14] = 7'b0000110;
    hex_seg[15] = 7'b0001110;
  end

  // Model: position within the frame in cycles, frozen while disabled.
  int          m_pos;
  logic [15:0] m_pend_val, m_disp_val;
  logic [3:0]  m_pend_dp, m_disp_dp;
  logic        m_pend_blz, m_disp_blz;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;
  logic [3:0]  exp_an;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    int d;
    logic [15:0] upper;
    logic wrap_now;
    if (!rst_n) begin
      model_valid = 1'b1;
      m_pos = 0;
      m_pend_val = '0; m_pend_dp = '0; m_pend_blz = 1'b0;
      m_disp_val = '0; m_disp_dp = '0; m_disp_blz = 1'b0;
      exp_seg = 7'h7f; exp_dp = 1'b1; exp_an = 4'hf; exp_fd = 1'b0;
    end else begin
      d = m_pos / DIV;
      upper = m_disp_val >> (4 * d);
      if (enable) begin
        exp_an  = ~(4'b0001 << d);
        exp_seg = (m_disp_blz && d > 0 && upper == 16'd0) ? 7'h7f : hex_seg[upper[3:0]];
        exp_dp  = ~m_disp_dp[d];
      end else begin
        exp_an = 4'hf; exp_seg = 7'h7f; exp_dp = 1'b1;
      end
      wrap_now = enable && (m_pos == FRAME - 1);
      exp_fd = wrap_now;
      if (wrap_now) begin
        m_disp_val = load ? value    : m_pend_val;
        m_disp_dp  = load ? dp_in    : m_pend_dp;
        m_disp_blz = load ? blank_lz : m_pend_blz;
      end
      if (load) begin
        m_pend_val = value; m_pend_dp = dp_in; m_pend_blz = blank_lz;
      end
      if (enable) m_pos = (m_pos + 1) % FRAME;
    end
  end

  always @(posedge clk) if (released) cyc++;

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_seg", 32'(seg), 32'(exp_seg));
      chk("model_dp",  32'(dp), 32'(exp_dp));
      chk("model_an",  32'(an), 32'(exp_an));
      chk("model_frame_done", 32'(frame_done), 32'(exp_fd));
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic blz);
    load = 1'b1; value = v; dp_in = d; blank_lz = blz;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int first_fd;
    rst_n = 1'b0; enable = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; released = 1'b1;

    first_fd = 0;
    for (int k = 1; k <= 20; k++) begin
      wait_cyc(k);
      if (k == 1) begin
        chk("reset_an", 32'(an), 32'(4'b1110));
        chk("reset_seg", 32'(seg), 32'(7'b1000000));
      end
      if (frame_done === 1'b1 && first_fd == 0) first_fd = k;
    end
    chk("first_frame_done", 32'(first_fd), 32'd16);

    // Mid-frame load: stays invisible until the next frame.
    do_load(16'hA3F0, 4'b0000, 1'b0);
    wait_cyc(21); load = 1'b0;
    wait_cyc(25); chk("tear_old_digit2", 32'(seg), 32'(7'b1000000));
    wait_cyc(33); chk("scan_d0_seg", 32'(seg), 32'(7'b1000000)); chk("scan_d0_an", 32'(an), 32'(4'b1110));
    wait_cyc(37); chk("scan_d1_seg", 32'(seg), 32'(7'b0001110)); chk("scan_d1_an", 32'(an), 32'(4'b1101));
    wait_cyc(41); chk("scan_d2_seg", 32'(seg), 32'(7'b0110000)); chk("scan_d2_an", 32'(an), 32'(4'b1011));
    wait_cyc(45); chk("scan_d3_seg", 32'(seg), 32'(7'b0001000)); chk("scan_d3_an", 32'(an), 32'(4'b0111));

    wait_cyc(48); do_load(16'h0050, 4'b0000, 1'b1);
    wait_cyc(49); load = 1'b0;
    wait_cyc(65); chk("lz_d0", 32'(seg), 32'(7'b1000000));
    wait_cyc(69); chk("lz_d1", 32'(seg), 32'(7'b0010010));
    wait_cyc(73); chk("lz_d2", 32'(seg), 32'(7'b1111111));
    wait_cyc(77); chk("lz_d3", 32'(seg), 32'(7'b1111111));

    // Load sampled on the wrap-tick edge is shown in the frame that starts.
    wait_cyc(79); do_load(16'h0000, 4'b0000, 1'b1);
    wait_cyc(80); load = 1'b0;
    wait_cyc(81); chk("wrapload_d0", 32'(seg), 32'(7'b1000000));
    wait_cyc(85); chk("wrapload_d1", 32'(seg), 32'(7'b1111111)); chk("wrapload_d1_an", 32'(an), 32'(4'b1101));

    wait_cyc(98); do_load(16'h1234, 4'b0000, 1'b0);
    wait_cyc(99); load = 1'b0;
    wait_cyc(101); chk("tear_old_blank_d1", 32'(seg), 32'(7'b1111111));
    wait_cyc(112); do_load(16'h1234, 4'b0100, 1'b0);
    wait_cyc(113); load = 1'b0; chk("tear_new_d0", 32'(seg), 32'(7'b0011001));

    wait_cyc(137);
    chk("dp_d2_seg", 32'(seg), 32'(7'b0100100)); chk("dp_d2_dp", 32'(dp), 32'd0);
    enable = 1'b0;
    wait_cyc(138); chk("dark_dp", 32'(dp), 32'd1);
    wait_cyc(140); chk("dark_an", 32'(an), 32'(4'b1111));
    wait_cyc(147); enable = 1'b1;
    wait_cyc(148); chk("resume_an", 32'(an), 32'(4'b1011)); chk("resume_dp", 32'(dp), 32'd0);
    wait_cyc(151); chk("next_d3_an", 32'(an), 32'(4'b0111)); chk("next_d3_dp", 32'(dp), 32'd1);

    // Reset mid-scan with a load pending: both must be discarded.
    wait_cyc(160); rst_n = 1'b0; do_load(16'hFFFF, 4'b1111, 1'b0);
    wait_cyc(162); rst_n = 1'b1; load = 1'b0;
    wait_cyc(163); chk("rst2_an", 32'(an), 32'(4'b1110)); chk("rst2_seg", 32'(seg), 32'(7'b1000000));
    wait_cyc(179); chk("rst2_no_pending", 32'(seg), 32'(7'b1000000));
    wait_cyc(185);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for an N-digit common-anode seven-segment display. It accepts a packed hex value, one decimal point per digit, and a leading-zero-blank option, and scans one digit at a time at a programmable refresh rate. It is the parametrised successor of the team's single-digit combinational decoder. It sits between the datapath/register file and the board display pins, and it double-buffers the displayed value so that a frame never shows a mix of old and new data.

## Interface
- `N_DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `CLK_DIV`, default 50000: clock cycles per digit slot; legal minimum 2.
- `SEG_ACTIVE_LOW`, default 1: 1 means a segment is lit when its output is 0.
- `AN_ACTIVE_LOW`, default 1: 1 means a digit is enabled when its anode output is 0.
- `clk`  in  1: system clock; all state is updated on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `enable`  in  1: 1 = scanning runs; 0 = display dark and counters frozen.
- `load`  in  1: single-cycle strobe that captures `value`, `dp_in` and `blank_lz` into the pending buffer.
- `value`  in  4*N_DIGITS: hex nibbles; nibble i drives digit i; digit 0 is the rightmost (least significant) digit.
- `dp_in`  in  N_DIGITS: decimal point for digit i.
- `blank_lz`  in  1: leading-zero blanking enable.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, registered.
- `dp`  out  1: decimal point, registered.
- `an`  out  N_DIGITS: digit enables, registered; at most one digit is active at a time.
- `frame_done`  out  1: one-cycle pulse on each wrap of the digit index.

## Operation
- **Prescaler.** `div_cnt` is $clog2(CLK_DIV) bits wide and counts 0..CLK_DIV-1, then wraps to 0. `tick` = (`div_cnt` == CLK_DIV-1) && `enable`.
- **Digit index.** `idx` is max(1, $clog2(N_DIGITS)) bits wide. On `tick`, `idx` increments; when it is at N_DIGITS-1 it wraps to 0 instead. `frame_done` is registered and is 1 for exactly the cycle after the tick that wrapped `idx`. When N_DIGITS=1, every tick counts as a wrap.
- **Buffering.** When `load`=1, the inputs are copied into the pending registers. On a wrapping tick, the pending registers are copied into the display registers.
  - If `load` and a wrapping tick occur in the same cycle, the freshly loaded inputs are bypassed straight into the display registers.
  - Consequence: a loaded value becomes visible from the start of the next frame, and never mid-frame.
- **Decode (hex 0..F, active-low form).** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - When SEG_ACTIVE_LOW=0, `seg` and `dp` are inverted.
- **Blanking.** With `blank_lz`=1, digit i (i>0) is blanked when nibble i and every higher nibble are 0. Digit 0 is never blanked.
  - A blanked digit drives all segments off, but its `dp` still follows `dp_in`.
- **Enable.** With `enable`=0, `an` is all-off, `seg` and `dp` are off, and `div_cnt` and `idx` hold their values. `load` still captures into the pending buffer.
- **Anode drive.** `an` is one-hot on `idx`, with polarity set by AN_ACTIVE_LOW.

## Timing
- **Reset values.** `div_cnt`=0, `idx`=0, pending and display registers=0, `blank_lz` register=0. `seg`, `dp` and `an` are all off (in their respective polarities). `frame_done`=0.
- **Reset mid-scan.** Asserting reset at any point returns the block to the reset values on the next edge. Any pending load is discarded.
- **Output latency.** `seg`, `an` and `dp` are registered from (`idx`, display registers, `enable`), with 1 cycle of latency.
  - The first edge after `rst_n` rises (with `enable`=1) drives digit 0 showing 0.
  - `tick` occurs at cycles CLK_DIV-1, 2·CLK_DIV-1, and so on after reset release. The outputs move to the next digit on the following cycle.
- **Frame period.** One frame is N_DIGITS·CLK_DIV cycles, so `frame_done` pulses exactly every N_DIGITS·CLK_DIV cycles.
- **Load to display.** Worst-case latency from `load` to the value appearing on the pins is one full frame plus 1 cycle.
- **Enable toggling.** When `enable` falls, the outputs go dark 1 cycle later. When `enable` rises, scanning resumes from the frozen `div_cnt` and `idx`.

## Structure
- **Package `seven_seg_pkg`.** Holds:
  - the 16-entry active-low segment constant table;
  - `SEG_OFF` (7'b1111111);
  - a `hex_to_seg` function.
- **Sub-module `seven_seg_decode`.** Combinational: 4-bit nibble plus blank flag in, 7-bit active-low segment pattern out. It has a single instance, fed by the nibble currently selected by the multiplexer.
- **Top level.** Contains the prescaler, index counter, pending/display buffers, blanking logic and output registers.

## Test plan
All scenarios use N_DIGITS=4 and CLK_DIV=4.
- **Reset.** Hold `rst_n`=0 for 3 cycles, then release with `enable`=1.
  - `an`=1110 and `seg`=1000000 one cycle after release.
  - The first `frame_done` arrives 16 cycles after release.
- **Scan and hex decode.** Load 16'hA3F0, then wait a frame.
  - Digit patterns are, for digit 0..3: 1000000, 0001110, 0110000, 0001000.
  - `an` steps 1110 → 1101 → 1011 → 0111 every 4 cycles.
- **Leading-zero blanking.** Load 16'h0050 with `blank_lz`=1.
  - Digits 3 and 2 show 1111111.
  - Digit 1 shows 0010010 and digit 0 shows 1000000.
  - Load 16'h0000: only digit 0 is lit, showing 1000000.
- **Tear-free update.** Issue `load` in the middle of a frame.
  - The remaining digits of the current frame still show the old value.
  - The new value appears at digit 0 of the next frame.
  - Issue `load` on the wrap-tick cycle itself: the new value is shown immediately in the frame that starts.
- **Enable and decimal point.** Deassert `enable` for 10 cycles while `idx`=2.
  - `an`=1111 and no `frame_done` pulses during that time.
  - Scanning resumes at digit 2.
  - With `dp_in`=4'b0100, `dp`=0 only while digit 2 is active.
